cnt_sched: RTL and testbench
============================

Name: cnt_sched

Overview:
- Round-robin scheduler that shares one enable-counter timing resource among NREQ requesters.
- Each requester asks for a delay of len ticks. The block arbitrates, grants, clears and runs the counter, then pulses done to the winner.
- Sits between control FSMs needing timed waits and a single internal tick counter, so the design avoids one counter per client.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, counter and length width in bits

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level; held until done or withdrawn
- len  in  NREQ*W  packed lengths; requester i uses len[i*W +: W]
- tick  in  1  count-enable strobe; counter advances only on cycles with tick=1
- grant  out  NREQ  one-hot current owner; all-zero when idle
- busy  out  1  high in RUN and DONE
- done  out  NREQ  one-cycle pulse to the owner on completion
- abort  out  1  one-cycle pulse when the owner drops req during RUN
- cnt_val  out  W  live counter value, for debug and observation

Behaviour:
- Reset state: state=IDLE, grant=0, done=0, abort=0, busy=0, counter=0, rr pointer=NREQ-1 (requester 0 wins the first arbitration).
- IDLE:
  - If req!=0, choose the first set req scanning from ptr+1 upward, wrapping modulo NREQ.
  - Register owner index and len[owner]; synchronously clear the counter.
  - Next cycle: grant[owner]=1, busy=1, state=RUN.
  - Latency from req to grant is 1 cycle.
- RUN:
  - Counter increments on tick=1, holds on tick=0.
  - When cnt_val==len_q-1 and tick=1, go to DONE. The counter then reads len_q and holds.
  - len_q==0: go to DONE on the first RUN cycle regardless of tick (zero-length wait).
  - len_q==2^W-1 is the maximum; arithmetic is W-bit and no wrap occurs before completion.
  - If req[owner]==0 in any RUN cycle, abort has priority over completion in the same cycle: pulse abort, clear grant, state=IDLE, no done.
- DONE (one cycle):
  - done[owner]=1, grant held.
  - Next cycle: grant=0, busy=0, ptr=owner, state=IDLE.
- Back-to-back: a requester re-raising or holding req after done is eligible only in the following IDLE cycle, behind other pending requesters under round-robin order.
- Requests from non-owners during RUN/DONE are ignored until IDLE; they are not latched.
- len is sampled only in IDLE; later changes have no effect on the current job.
- Reset mid-operation: immediate return to the reset state; no done or abort pulse.
- Minimum cycles per job: IDLE, RUN, DONE, IDLE = 3 cycles for len=0.

Optional Feature:
- SCHED_FIXED_PRIO_EN defined: round-robin pointer removed; the lowest-index set req always wins; ptr is not updated in DONE.
- Undefined: round-robin as specified above.

Decomposition:
- Package cnt_sched_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - function rr_pick(req, ptr) returning the winner index
- Sub-module tick_counter (params W; ports clk, reset async, clr sync, en, q): W-bit up counter. Clear has priority over enable.

Test Plan:
- Single request: req=4'b0001, len[0]=3, tick=1 every cycle -> grant=0001 one cycle after req; done[0] pulses 3 ticks after RUN entry, cnt_val=3 at done; grant=0 the cycle after.
- Round-robin fairness: req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0; each done pulse matches the granted index.
- Tick gating: len=2, tick asserted every 3rd cycle -> done only after the 2nd tick; cnt_val holds between ticks.
- Zero length: len=0, tick=0 constant -> done pulses on the cycle after RUN entry; 3-cycle job.
- Abort: owner drops req after 1 tick of len=5 -> abort pulses once, no done, grant=0; next pending requester granted the cycle after IDLE.
- Reset mid-RUN: assert reset while cnt_val=2 -> all outputs 0 immediately; after release, req=1000 and 0001 together -> requester 0 wins. Under SCHED_FIXED_PRIO_EN, repeat the fairness test -> requester 0 always wins.

Source files
------------

// File: rtl/cnt_sched_pkg.sv
// Shared types and arbitration helpers for the cnt_sched counter scheduler.
// Index widths are fixed at 3 bits so the helpers serve any NREQ up to 8.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int MAX_REQ = 8;

  // Scan upward from ptr+1, wrapping modulo nreq. The loop runs from the far
  // end back toward ptr+1, so the nearest set request is assigned last and wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int nreq);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= nreq) begin
        idx = 3'((int'(ptr) + k) % nreq);
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] fixed_pick(input logic [7:0] req, input int nreq);
    logic [2:0] pick;
    pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq && req[k]) pick = 3'(k);
    end
    return pick;
  endfunction

endpackage

// File: rtl/cnt_sched_tick_counter.sv
// W-bit up counter with synchronous clear (wins over enable) and async reset.
module tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_en)  o_q <= o_q + W'(1);
  end

endmodule

// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one tick counter among NREQ requesters.
// Define SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_len,
  input  logic              i_tick,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_busy,
  output logic [NREQ-1:0]   o_done,
  output logic              o_abort,
  output logic [W-1:0]      o_cnt_val
);

  state_t          r_state;
  state_t          w_stateNext;
  logic [2:0]      r_owner;
  logic [W-1:0]    r_len;
  logic [7:0]      w_reqPad;
  logic [2:0]      w_pick;
  logic [W-1:0]    w_winLen;
  logic [NREQ-1:0] w_ownerOh;
  logic            w_ownerReq;
  logic            w_start;
  logic            w_abort;
  logic [W-1:0]    w_cnt;

  always_comb begin
    w_reqPad = '0;
    w_reqPad[NREQ-1:0] = i_req;
  end

`ifdef SCHED_FIXED_PRIO_EN
  assign w_pick = fixed_pick(w_reqPad, NREQ);
`else
  logic [2:0] r_ptr;

  // Reset value NREQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_ptr <= 3'(NREQ - 1);
    else if (r_state == S_DONE) r_ptr <= r_owner;
  end

  assign w_pick = rr_pick(w_reqPad, r_ptr, NREQ);
`endif

  always_comb begin
    w_winLen = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == w_pick) w_winLen = i_len[i*W +: W];
    end
  end

  assign w_ownerOh  = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_ownerReq = w_reqPad[r_owner];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_start) begin
        r_owner <= w_pick;
        r_len   <= w_winLen;
      end
    end
  end

  // Abort is checked before completion so a dropped request never sees done.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_start     = 1'b1;
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_ownerReq) begin
          w_abort     = 1'b1;
          w_stateNext = S_IDLE;
        end else if ((r_len == '0) || (i_tick && (w_cnt == r_len - W'(1)))) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  tick_counter #(.W(W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_start),
    .i_en  ((r_state == S_RUN) && i_tick && (r_len != '0) && w_ownerReq),
    .o_q   (w_cnt)
  );

  assign o_busy    = (r_state == S_RUN) || (r_state == S_DONE);
  assign o_grant   = o_busy ? w_ownerOh : '0;
  assign o_done    = (r_state == S_DONE) ? w_ownerOh : '0;
  assign o_abort   = w_abort;
  assign o_cnt_val = w_cnt;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed self-checking bench for cnt_sched (NREQ=4, W=4).
// Inputs change and outputs are checked on the falling clock edge.
module tb_cnt_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic        tick;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  done;
  logic        abort;
  logic [3:0]  cntVal;

  int compared   = 0;
  int mismatched = 0;

  cnt_sched #(.NREQ(4), .W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_len     (len),
    .i_tick    (tick),
    .o_grant   (grant),
    .o_busy    (busy),
    .o_done    (done),
    .o_abort   (abort),
    .o_cnt_val (cntVal)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l, input logic t);
    req  = r;
    len  = l;
    tick = t;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Observed vector layout: {grant, busy, done, abort, cnt_val}
  task automatic checkOutput(input string tag, input logic [3:0] eGrant, input logic eBusy,
                             input logic [3:0] eDone, input logic eAbort, input logic [3:0] eCnt);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {grant, busy, done, abort, cntVal};
    exp = {eGrant, eBusy, eDone, eAbort, eCnt};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed grant/busy/done/abort/cnt=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
             tag, obs[13:10], obs[9], obs[8:5], obs[4], obs[3:0],
             exp[13:10], exp[9], exp[8:5], exp[4], exp[3:0]);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;
    reset = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("reset_state", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    reset = 1'b0;

    $display("[TB] single request, len=3");
    applyStimulus(4'b0001, 16'h0003, 1'b1);
    checkOutput("single_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    checkOutput("single_grant", 4'b0001, 1'b1, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    checkOutput("single_cnt1", 4'b0001, 1'b1, 4'b0000, 1'b0, 4'd1);
    nextCycle();
    checkOutput("single_cnt2", 4'b0001, 1'b1, 4'b0000, 1'b0, 4'd2);
    nextCycle();
    checkOutput("single_done", 4'b0001, 1'b1, 4'b0001, 1'b0, 4'd3);
    applyStimulus(4'b0000, 16'h0003, 1'b1);
    nextCycle();
    checkOutput("single_release", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd3);

    $display("[TB] round-robin fairness, all len=1");
    pulseReset();
    applyStimulus(4'b1111, 16'h1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
`ifdef SCHED_FIXED_PRIO_EN
      oh = 4'b0001;
`else
      oh = 4'b0001 << (k % 4);
`endif
      checkOutput("rr_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, (k == 0) ? 4'd0 : 4'd1);
      nextCycle();
      checkOutput("rr_grant", oh, 1'b1, 4'b0000, 1'b0, 4'd0);
      nextCycle();
      checkOutput("rr_done", oh, 1'b1, oh, 1'b0, 4'd1);
      nextCycle();
    end
    applyStimulus(4'b0000, 16'h0000, 1'b0);

    $display("[TB] tick gating, len=2, tick every third cycle");
    applyStimulus(4'b0010, 16'h0020, 1'b0);
    checkOutput("gate_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd1);
    nextCycle();
    checkOutput("gate_run0a", 4'b0010, 1'b1, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    checkOutput("gate_run0b", 4'b0010, 1'b1, 4'b0000, 1'b0, 4'd0);
    tick = 1'b1;
    nextCycle();
    tick = 1'b0;
    checkOutput("gate_run1a", 4'b0010, 1'b1, 4'b0000, 1'b0, 4'd1);
    nextCycle();
    checkOutput("gate_run1b", 4'b0010, 1'b1, 4'b0000, 1'b0, 4'd1);
    nextCycle();
    checkOutput("gate_run1c", 4'b0010, 1'b1, 4'b0000, 1'b0, 4'd1);
    tick = 1'b1;
    nextCycle();
    applyStimulus(4'b0000, 16'h0020, 1'b0);
    checkOutput("gate_done", 4'b0010, 1'b1, 4'b0010, 1'b0, 4'd2);
    nextCycle();
    checkOutput("gate_release", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd2);

    $display("[TB] zero length, tick held low");
    applyStimulus(4'b0100, 16'h0000, 1'b0);
    nextCycle();
    checkOutput("zero_run", 4'b0100, 1'b1, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    checkOutput("zero_done", 4'b0100, 1'b1, 4'b0100, 1'b0, 4'd0);
    nextCycle();
    checkOutput("zero_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd0);

    $display("[TB] abort after one tick of len=5");
    applyStimulus(4'b0011, 16'h0015, 1'b1);
    nextCycle();
    checkOutput("abort_grant", 4'b0001, 1'b1, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    checkOutput("abort_cnt1", 4'b0001, 1'b1, 4'b0000, 1'b0, 4'd1);
    req = 4'b0010;
    #1;
    checkOutput("abort_pulse", 4'b0001, 1'b1, 4'b0000, 1'b1, 4'd1);
    nextCycle();
    checkOutput("abort_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd1);
    nextCycle();
    checkOutput("abort_next_grant", 4'b0010, 1'b1, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    applyStimulus(4'b0000, 16'h0000, 1'b1);
    checkOutput("abort_next_done", 4'b0010, 1'b1, 4'b0010, 1'b0, 4'd1);
    nextCycle();

    $display("[TB] reset during RUN");
    applyStimulus(4'b0100, 16'h0500, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("mid_cnt2", 4'b0100, 1'b1, 4'b0000, 1'b0, 4'd2);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(4'b1001, 16'h1001, 1'b1);
    nextCycle();
    checkOutput("post_reset_winner", 4'b0001, 1'b1, 4'b0000, 1'b0, 4'd0);
    nextCycle();
    applyStimulus(4'b0000, 16'h0000, 1'b0);
    checkOutput("post_reset_done", 4'b0001, 1'b1, 4'b0001, 1'b0, 4'd1);
    nextCycle();
    checkOutput("final_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
